booth_mult_seq: RTL and testbench

//   Parametrised sequential radix-2 Booth multiplier: control FSM, iteration counter and A/Q/Q-1 datapath in one block.

---
 rtl/booth_mult_seq.sv | 117 +++++++++++
 tb/tb_booth_mult_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and signed/unsigned operand select.
// Optional BOOTH_SKIP_EN: iterations whose Booth pair is 00/11 shift directly in OP, without visiting SHIFT.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, OP, SHIFT, DONE} state_t;

  state_t          state;
  logic [N:0]      a;
  logic [N-1:0]    m;
  logic [N-1:0]    q;
  logic            q_m1;
  logic [CW-1:0]   count;

  logic [N:0]      m_ext;
  logic [N:0]      a_arith;
  logic [2*N+1:0]  acc_sh;
  logic            last;

  always_comb begin
    m_ext   = {m[N-1], m};
    a_arith = a;
    unique case ({q[0], q_m1})
      2'b01:   a_arith = a + m_ext;
      2'b10:   a_arith = a - m_ext;
      default: a_arith = a;
    endcase
    // Shift always sees the current A: add/sub results are written back in OP before SHIFT runs.
    acc_sh = {a[N], a, q, q_m1} >> 1;
    last   = (count == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= {op_signed & multiplicand[WIDTH-1], multiplicand};
            q     <= {op_signed & multiplier[WIDTH-1], multiplier};
            a     <= '0;
            q_m1  <= 1'b0;
            count <= CW'(N);
            busy  <= 1'b1;
            state <= OP;
          end
        end
        OP: begin
`ifdef BOOTH_SKIP_EN
          if (q[0] ^ q_m1) begin
            a     <= a_arith;
            state <= SHIFT;
          end else begin
            a     <= acc_sh[2*N+1:N+1];
            q     <= acc_sh[N:1];
            q_m1  <= acc_sh[0];
            count <= count - CW'(1);
            if (last) begin
              product <= acc_sh[2*WIDTH:1];
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              state <= OP;
            end
          end
`else
          a     <= a_arith;
          state <= SHIFT;
`endif
        end
        SHIFT: begin
          a     <= acc_sh[2*N+1:N+1];
          q     <= acc_sh[N:1];
          q_m1  <= acc_sh[0];
          count <= count - CW'(1);
          if (last) begin
            product <= acc_sh[2*WIDTH:1];
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= OP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=8); latency expectations follow BOOTH_SKIP_EN.
module tb_booth_mult_seq;

  localparam int W = 8;
  localparam int N = W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           op_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_passed = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_signed    (op_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Edges from accepting edge (counted as 1) to the edge entering DONE.
  function automatic int exp_latency(input bit sgn, input logic [W-1:0] mp);
    logic [N-1:0] qe;
    bit prev;
    int pairs;
    qe    = {sgn & mp[W-1], mp};
    prev  = 1'b0;
    pairs = 0;
    for (int i = 0; i < N; i++) begin
      if (qe[i] != prev) pairs++;
      prev = qe[i];
    end
`ifdef BOOTH_SKIP_EN
    return N + pairs + 1;
`else
    return 2 * N + 1;
`endif
  endfunction

  task automatic run_op(input string tag, input bit sgn, input logic [W-1:0] mc,
                        input logic [W-1:0] mp, input logic [2*W-1:0] exp, input bit poke);
    int n;
    @(negedge clk);
    op_signed    = sgn;
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke && n == 3) begin
        op_signed    = 1'b0;
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
      end else if (poke && n == 4) begin
        start = 1'b0;
      end
      if (done) break;
    end
    check({tag, "_lat"}, n + 1, exp_latency(sgn, mp));
    check({tag, "_prod"}, product, exp);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n_done;
    reset = 1'b1;
    start = 1'b0;
    op_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("s3x5",      1'b1, 8'd3,   8'd5,   16'd15,    1'b0);
    run_op("s-128x-128",1'b1, 8'h80,  8'h80,  16'd16384, 1'b0);
    run_op("s-7x6",     1'b1, 8'hF9,  8'd6,   16'hFFD6,  1'b0);
    run_op("u255x255",  1'b0, 8'd255, 8'd255, 16'd65025, 1'b0);
    run_op("u0x200",    1'b0, 8'd0,   8'd200, 16'd0,     1'b0);
    run_op("s0x0",      1'b1, 8'd0,   8'd0,   16'd0,     1'b0);
    run_op("s1x1",      1'b1, 8'd1,   8'd1,   16'd1,     1'b0);
    run_op("poke3x5",   1'b1, 8'd3,   8'd5,   16'd15,    1'b1);
    run_op("after-7x6", 1'b1, 8'hF9,  8'd6,   16'hFFD6,  1'b0);

    // Abort in iteration 4 with an asynchronous reset between edges.
    @(negedge clk);
    op_signed = 1'b1; multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_prod", product, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_nodone", n_done, 0);
    check("abort_prod_hold", product, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
